prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Loads the Hack program memory from a byte stream, then releases the CPU.
- It is the writer for the instruction memory that the CPU reads through pc/instruction.
- Accepts a length header followed by big-endian 16-bit words over a valid/ready byte handshake, and writes each word to sequential addresses from 0.
- Holds the CPU in reset until the load has finished without error.

Parameters:
ADDR_W, 15, program memory address width (32K words)
MAX_WORDS, 32768, largest legal header word count

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
rx_data  input  8  stream byte
rx_valid  input  1  rx_data holds a valid byte
rx_ready  output  1  loader can accept a byte this cycle
wr_en  output  1  program memory write strobe, one cycle per word
wr_addr  output  ADDR_W  program memory write address
wr_data  output  16  program memory write data
cpu_reset  output  1  active-high reset to the CPU
busy  output  1  load in progress
done  output  1  sticky; load completed successfully
error  output  1  sticky; load aborted
words_loaded  output  ADDR_W+1  number of words written so far in this load

Behaviour:
- Reset values (reset=0, takes effect immediately):
  - state = IDLE.
  - rx_ready, wr_en, busy, done and error = 0.
  - wr_addr, wr_data and words_loaded = 0.
  - cpu_reset = 1.
  - Program memory contents are left untouched.
- States: IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, DONE, ERROR.
  - Checksum build only: also CHK_HI and CHK_LO.
- Byte transfer:
  - A byte is accepted on a clock edge where rx_valid=1 and rx_ready=1.
  - rx_ready=1 only in HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK_HI and CHK_LO.
  - rx_ready does not depend combinationally on rx_valid.
- IDLE:
  - start=1 → HDR_HI.
  - On entry to HDR_HI: words_loaded=0, done=0, error=0, busy=1, cpu_reset=1.
- Header:
  - HDR_HI captures N[15:8]; HDR_LO captures N[7:0].
  - After HDR_LO accept: N > MAX_WORDS → ERROR; N == 0 → DONE (or CHK_HI when checksum is enabled); otherwise → DAT_HI.
- Data words:
  - DAT_HI captures wr_data[15:8]; DAT_LO captures wr_data[7:0], then → WRITE.
  - WRITE lasts exactly one cycle: wr_en=1, wr_addr = words_loaded[ADDR_W-1:0], wr_data = the assembled word.
  - wr_en therefore rises on the cycle after the low byte is accepted.
  - In WRITE, words_loaded increments by 1.
  - If the new count == N, the next state is DONE (or CHK_HI); otherwise DAT_HI.
- wr_en is 0 in every state except WRITE.
- wr_addr and wr_data hold their last values outside WRITE.
- DONE:
  - busy=0, done=1, cpu_reset=0.
  - Stays in DONE until start or reset.
- ERROR:
  - busy=0, error=1, cpu_reset=1.
  - Words already written stay in memory.
  - Stays in ERROR until start or reset.
- start while busy=1 is ignored.
- start in DONE or ERROR restarts the load: → HDR_HI and cpu_reset returns to 1 on the same edge.
- Reset asserted mid-load aborts immediately to the reset values; no partial write strobe is issued.
- N == MAX_WORDS = 32768 is legal.
  - Addresses 0..32767 are written; words_loaded ends at 32768.
  - This is why words_loaded is one bit wider than ADDR_W.

Optional Feature:
Macro: PROG_LOADER_CHECKSUM_EN
- Defined:
  - A running 16-bit sum (mod 2^16) of every written data word is kept; it is cleared on entry to HDR_HI.
  - After the last word, CHK_HI and CHK_LO accept a 16-bit big-endian trailer.
  - Trailer == sum → DONE. Trailer != sum → ERROR, with cpu_reset held at 1.
  - When N == 0, the trailer must be 0x0000.
- Not defined:
  - No trailer byte is expected, and the CHK states and sum register are absent.
  - The load goes to DONE straight after the last WRITE, or after HDR_LO when N == 0.

Test Plan:
- Basic load: pulse start, stream 00 03 | 12 34 | AB CD | FF 00 with rx_valid held at 1.
  - Three wr_en pulses: addr 0/0x1234, addr 1/0xABCD, addr 2/0xFF00.
  - Then done=1, cpu_reset=0, words_loaded=3.
- Backpressure and gaps: same stream with rx_valid toggling 1-0-0-1.
  - Identical writes to the basic load.
  - No byte is accepted while rx_valid=0.
  - Exactly one wr_en per word.
- Empty load and oversize header:
  - Header 00 00 → DONE with no wr_en.
  - Header 80 01 (32769) → error=1, cpu_reset=1, no wr_en.
- Reset mid-load: drive reset=0 after the 2nd data word's high byte.
  - All outputs return to reset values at once; state = IDLE.
  - A following start plus a full stream completes normally.
- Restart and ignored start:
  - start pulsed during DAT_LO is ignored.
  - After done=1, a new start clears done and reasserts cpu_reset in the same cycle, then reloads with new data.
- Checksum build: words 0x1234 and 0x0001.
  - Trailer 12 35 → done=1.
  - Trailer 12 36 → error=1, cpu_reset=1, words_loaded=2.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: loads the Hack program memory from a byte stream and holds the
// CPU in reset until the load has completed without error.
//
// Stream format: 16-bit big-endian word count N, then N big-endian 16-bit
// words, written to program memory addresses 0..N-1. With
// PROG_LOADER_CHECKSUM_EN defined, a 16-bit big-endian trailer follows the
// last word; it must equal the mod-2^16 sum of all written words.
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   start          one-cycle pulse, begins a load from IDLE, DONE or ERROR
//   rx_data/valid  incoming byte and its valid flag
//   rx_ready       loader accepts a byte this cycle (state-only, not from rx_valid)
//   wr_en/addr/data program memory write port, one strobe per word
//   cpu_reset      active-high CPU reset, low only in DONE
//   busy/done/error load status (done and error are sticky until start)
//   words_loaded   words written so far in this load (one bit wider than ADDR_W)
//
// Optional build macro: PROG_LOADER_CHECKSUM_EN (trailer checksum check).
module prog_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CHK_HI,
    S_CHK_LO
`endif
  } state_t;

  // State reached after the last word (or after an empty header).
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK_HI;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t             state;
  state_t             nxt;
  logic [15:0]        hdr_n;
  logic [7:0]         hi_byte;
  logic [15:0]        rx_word;
  logic [ADDR_W:0]    cnt_inc;
  logic               accept;
  logic               start_load;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0]        sum;
`endif

  assign accept     = rx_valid && rx_ready;
  assign rx_word    = {hi_byte, rx_data};
  assign cnt_inc    = words_loaded + (ADDR_W+1)'(1);
  assign start_load = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    rx_ready  = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) nxt = S_HDR_HI;
      end
      S_HDR_HI: begin
        rx_ready = 1'b1;
        if (accept) nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (32'(rx_word) > 32'(MAX_WORDS)) nxt = S_ERROR;
          else if (rx_word == 16'd0)         nxt = S_FIN;
          else                               nxt = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        rx_ready = 1'b1;
        if (accept) nxt = S_DAT_LO;
      end
      S_DAT_LO: begin
        rx_ready = 1'b1;
        if (accept) nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        nxt   = (32'(cnt_inc) == 32'(hdr_n)) ? S_FIN : S_DAT_HI;
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) nxt = S_HDR_HI;
      end
      S_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) nxt = S_HDR_HI;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK_HI: begin
        rx_ready = 1'b1;
        if (accept) nxt = S_CHK_LO;
      end
      S_CHK_LO: begin
        rx_ready = 1'b1;
        if (accept) nxt = (rx_word == sum) ? S_DONE : S_ERROR;
      end
`endif
      default: begin
        busy = 1'b0;
        nxt  = S_IDLE;
      end
    endcase
  end

  // Write port and counters: wr_addr/wr_data change only when the low byte
  // completes a word, so they are stable through WRITE and hold afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_addr      <= '0;
      wr_data      <= '0;
      words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      if (start_load) begin
        words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum          <= '0;
`endif
      end
      if (state == S_DAT_LO && accept) begin
        wr_addr <= words_loaded[ADDR_W-1:0];
        wr_data <= rx_word;
      end
      if (state == S_WRITE) begin
        words_loaded <= cnt_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum          <= sum + wr_data;
`endif
      end
    end
  end

  // Byte staging and header count; meaningful only while a load is active.
  always_ff @(posedge clk) begin
    if (accept && (state == S_HDR_HI || state == S_DAT_HI
`ifdef PROG_LOADER_CHECKSUM_EN
                   || state == S_CHK_HI
`endif
                   ))
      hi_byte <= rx_data;
    if (accept && state == S_HDR_LO)
      hdr_n <= rx_word;
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  prog_loader #(.ADDR_W(15), .MAX_WORDS(32768)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int acc_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] wq[$];
`ifdef PROG_LOADER_CHECKSUM_EN
  int tadj = 0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe pops one expected {addr,data}.
  always @(negedge clk) begin
    if (reset && wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[30:16]));
        chk("wr_data", 32'(wr_data), 32'(e[15:0]));
      end
    end
  end

  always @(posedge clk) if (reset && rx_valid && rx_ready) acc_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    logic r;
    rx_valid = 1'b0;
    repeat (gap) step();
    rx_data = b; rx_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk); r = rx_ready;
      step();
      if (r) break;
      n++;
      if (n > 50) begin chk("rx_timeout", 0, 1); break; end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int idx, input int gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
    exp_q.push_back({1'b0, 15'(idx), w});
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("end_timeout", 0, 1);
    step();
  endtask

  task automatic load(input int gap);
    int n;
    logic [15:0] s;
    n = wq.size(); s = 16'd0;
    send_byte(8'(n >> 8), gap);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      send_word(wq[i], i, gap);
      s = s + wq[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    s = s + 16'(tadj);
    send_byte(s[15:8], gap);
    send_byte(s[7:0], gap);
`endif
    wait_end();
  endtask

  int w0, a0;

  initial begin
    clk = 0; reset = 0; start = 0; rx_data = 8'h00; rx_valid = 0;
    #2;
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_words", 32'(words_loaded), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    step();

    // Basic load, rx_valid held high
    wq = '{16'h1234, 16'hABCD, 16'hFF00};
    w0 = wr_cnt; a0 = acc_cnt;
    pulse_start();
    chk("basic_busy", 32'(busy), 1);
    load(0);
    chk("basic_done", 32'(done), 1);
    chk("basic_cpu_reset", 32'(cpu_reset), 0);
    chk("basic_words", 32'(words_loaded), 3);
    chk("basic_wr_cnt", 32'(wr_cnt - w0), 3);
    chk("basic_q_empty", 32'(exp_q.size()), 0);

    // Restart from DONE, then same stream with 1-0-0-1 valid pattern
    w0 = wr_cnt; a0 = acc_cnt;
    pulse_start();
    chk("restart_done", 32'(done), 0);
    chk("restart_cpu_reset", 32'(cpu_reset), 1);
    chk("restart_words", 32'(words_loaded), 0);
    load(2);
    chk("gap_done", 32'(done), 1);
    chk("gap_words", 32'(words_loaded), 3);
    chk("gap_wr_cnt", 32'(wr_cnt - w0), 3);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("gap_accepts", 32'(acc_cnt - a0), 10);
`else
    chk("gap_accepts", 32'(acc_cnt - a0), 8);
`endif

    // Empty load
    wq = {};
    w0 = wr_cnt;
    pulse_start();
    load(0);
    chk("empty_done", 32'(done), 1);
    chk("empty_words", 32'(words_loaded), 0);
    chk("empty_wr_cnt", 32'(wr_cnt - w0), 0);

    // Oversize header 32769
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'h80, 0);
    send_byte(8'h01, 0);
    wait_end();
    chk("over_error", 32'(error), 1);
    chk("over_done", 32'(done), 0);
    chk("over_cpu_reset", 32'(cpu_reset), 1);
    chk("over_wr_cnt", 32'(wr_cnt - w0), 0);

    // Reset after the 2nd data word's high byte
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(16'h1111, 0, 0);
    send_byte(8'h22, 0);
    reset = 1'b0;
    #1;
    chk("mid_rx_ready", 32'(rx_ready), 0);
    chk("mid_wr_en", 32'(wr_en), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_error", 32'(error), 0);
    chk("mid_cpu_reset", 32'(cpu_reset), 1);
    chk("mid_wr_addr", 32'(wr_addr), 0);
    chk("mid_wr_data", 32'(wr_data), 0);
    chk("mid_words", 32'(words_loaded), 0);
    step();
    reset = 1'b1;
    step();
    chk("mid_q_empty", 32'(exp_q.size()), 0);
    chk("mid_idle_busy", 32'(busy), 0);
    wq = '{16'h5555, 16'h6666, 16'h7777};
    pulse_start();
    load(0);
    chk("after_rst_done", 32'(done), 1);
    chk("after_rst_words", 32'(words_loaded), 3);

    // start during DAT_LO is ignored
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hA5, 0);
    pulse_start();
    chk("ign_busy", 32'(busy), 1);
    chk("ign_rx_ready", 32'(rx_ready), 1);
    send_byte(8'h5A, 0);
    exp_q.push_back({1'b0, 15'd0, 16'hA55A});
    send_word(16'h0102, 1, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'hA6, 0);
    send_byte(8'h5C, 0);
`endif
    wait_end();
    chk("ign_done", 32'(done), 1);
    chk("ign_words", 32'(words_loaded), 2);
    chk("ign_q_empty", 32'(exp_q.size()), 0);

    // Header equal to MAX_WORDS is accepted
    pulse_start();
    send_byte(8'h80, 0);
    send_byte(8'h00, 0);
    chk("max_error", 32'(error), 0);
    chk("max_busy", 32'(busy), 1);
    chk("max_rx_ready", 32'(rx_ready), 1);
    send_word(16'hBEEF, 0, 0);
    step();
    chk("max_words", 32'(words_loaded), 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum trailer good and bad
    wq = '{16'h1234, 16'h0001};
    tadj = 0;
    pulse_start();
    load(0);
    chk("chk_good_done", 32'(done), 1);
    chk("chk_good_error", 32'(error), 0);
    tadj = 1;
    pulse_start();
    load(0);
    chk("chk_bad_error", 32'(error), 1);
    chk("chk_bad_done", 32'(done), 0);
    chk("chk_bad_cpu_reset", 32'(cpu_reset), 1);
    chk("chk_bad_words", 32'(words_loaded), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
